// File: rtl/fm_frame_seq_if.sv
// Host register bus for the FM frame sequencer: write strobe, address, write data
// and combinational read data. The sequencer never stalls, so bus_wait is tied low.
interface fm_frame_seq_if;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_wren;
  logic [31:0] bus_rddata;
  logic        bus_wait;

  modport master (output bus_addr, bus_wrdata, bus_wren, input bus_rddata, bus_wait);
  modport slave  (input bus_addr, bus_wrdata, bus_wren, output bus_rddata, bus_wait);
endinterface

// File: rtl/fm_frame_seq.sv
// FM frame sequencer: sample tick, operator slot walk, key-on/restart bookkeeping and
// saturating stereo mix. Define FMSEQ_VOLUME_EN for 4-bit per-side channel volume.
module fm_frame_seq #(
  parameter int NUM_CH     = 32,
  parameter int SAMPLE_DIV = 506,
  parameter int OP_W       = 13,
  parameter int OUT_W      = 16,
  parameter int ACC_W      = 22
) (
  input  logic                          clk,
  input  logic                          reset,
  fm_frame_seq_if.slave                 bus,
  output logic [$clog2(2*NUM_CH)-1:0]   op_sel,
  output logic                          op_next,
  output logic                          op_reset,
  output logic                          op_kon,
  output logic                          op_restart,
  input  logic signed [OP_W-1:0]        op_result,
  input  logic                          op_sum,
  output logic signed [OUT_W-1:0]       audio_l,
  output logic signed [OUT_W-1:0]       audio_r,
  output logic                          audio_valid
);
  localparam int NUM_OP = 2 * NUM_CH;
  localparam int SEL_W  = $clog2(NUM_OP);
  localparam int CH_W   = SEL_W - 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OP - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_START, S_PROC, S_NEXT, S_END} state_t;
  state_t state, state_nx;

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick, busy, overrun, ch_hit;
  logic [7:0]              frame_cnt;
  logic [CH_W-1:0]         ch_idx, cur_ch;
  logic [NUM_CH-1:0]       kon, en_l, en_r, kon_set, restart_pend, restart_act;
  logic [7:0]              rd_vol;
  logic signed [ACC_W-1:0] acc_l, acc_r, res_ext, add_l, add_r;
  logic                    unused_bits;

  assign tick    = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign busy    = (state != S_IDLE);
  assign ch_idx  = bus.bus_addr[CH_W-1:0];
  assign ch_hit  = bus.bus_addr[7] && (bus.bus_addr[6:0] < 7'(NUM_CH));
  assign cur_ch  = op_sel[SEL_W-1:1];
  assign op_kon     = kon[cur_ch];
  assign op_restart = restart_act[cur_ch];
  assign res_ext = {{(ACC_W-OP_W){op_result[OP_W-1]}}, op_result};
  assign bus.bus_wait = 1'b0;

`ifdef FMSEQ_VOLUME_EN
  logic [NUM_CH-1:0][3:0]  vol_l, vol_r;
  logic [5:0]              gain_l, gain_r;
  logic signed [ACC_W+5:0] prod_l, prod_r, shf_l, shf_r;
  assign gain_l = {2'b00, vol_l[cur_ch]} + 6'd1;
  assign gain_r = {2'b00, vol_r[cur_ch]} + 6'd1;
  assign prod_l = $signed({{6{res_ext[ACC_W-1]}}, res_ext}) * $signed({{ACC_W{1'b0}}, gain_l});
  assign prod_r = $signed({{6{res_ext[ACC_W-1]}}, res_ext}) * $signed({{ACC_W{1'b0}}, gain_r});
  assign shf_l  = prod_l >>> 4;
  assign shf_r  = prod_r >>> 4;
  assign add_l  = shf_l[ACC_W-1:0];
  assign add_r  = shf_r[ACC_W-1:0];
  assign rd_vol = {vol_r[ch_idx], vol_l[ch_idx]};
  assign unused_bits = ^{bus.bus_wrdata[31:14], bus.bus_wrdata[12:10],
                         shf_l[ACC_W+5:ACC_W], shf_r[ACC_W+5:ACC_W]};
`else
  assign add_l  = res_ext;
  assign add_r  = res_ext;
  assign rd_vol = 8'h00;
  assign unused_bits = ^{bus.bus_wrdata[31:14], bus.bus_wrdata[12:10], bus.bus_wrdata[7:0]};
`endif

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else                  return v[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 1'b1;

  // A kon rising edge arms a restart for the frame after the next Start.
  always_comb begin
    kon_set = '0;
    if (bus.bus_wren && ch_hit && bus.bus_wrdata[13] && !kon[ch_idx]) kon_set[ch_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kon  <= '0;
      en_l <= '0;
      en_r <= '0;
`ifdef FMSEQ_VOLUME_EN
      vol_l <= '0;
      vol_r <= '0;
`endif
    end else if (bus.bus_wren && ch_hit) begin
      kon[ch_idx]  <= bus.bus_wrdata[13];
      en_l[ch_idx] <= bus.bus_wrdata[8];
      en_r[ch_idx] <= bus.bus_wrdata[9];
`ifdef FMSEQ_VOLUME_EN
      vol_l[ch_idx] <= bus.bus_wrdata[3:0];
      vol_r[ch_idx] <= bus.bus_wrdata[7:4];
`endif
    end

  always_comb begin
    bus.bus_rddata = '0;
    if (ch_hit)                    bus.bus_rddata = {18'b0, kon[ch_idx], 3'b0, en_r[ch_idx], en_l[ch_idx], rd_vol};
    else if (bus.bus_addr == 8'h00) bus.bus_rddata = {31'b0, overrun};
    else if (bus.bus_addr == 8'h01) bus.bus_rddata = {16'b0, frame_cnt, 7'b0, busy};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    op_next  = 1'b0;
    case (state)
      S_IDLE:  if (tick) state_nx = S_START;
      S_START: state_nx = S_PROC;
      S_PROC:  state_nx = S_NEXT;
      S_NEXT: begin
        op_next  = 1'b1;
        state_nx = (op_sel == LAST) ? S_END : S_PROC;
      end
      S_END:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_sel       <= '0;
      op_reset     <= 1'b1;
      acc_l        <= '0;
      acc_r        <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      audio_valid  <= 1'b0;
      frame_cnt    <= '0;
      restart_pend <= '0;
      restart_act  <= '0;
      overrun      <= 1'b0;
    end else begin
      audio_valid  <= 1'b0;
      restart_pend <= restart_pend | kon_set;
      // A dropped tick outranks a same-cycle clear.
      if (tick && busy) overrun <= 1'b1;
      else if (bus.bus_wren && bus.bus_addr == 8'h00 && bus.bus_wrdata[0]) overrun <= 1'b0;
      case (state)
        S_START: begin
          restart_act  <= restart_pend;
          restart_pend <= kon_set;
          op_sel       <= '0;
        end
        S_PROC: if (!op_reset && op_sum) begin
          if (en_l[cur_ch]) acc_l <= acc_l + add_l;
          if (en_r[cur_ch]) acc_r <= acc_r + add_r;
        end
        S_NEXT: if (op_sel != LAST) op_sel <= op_sel + 1'b1;
        S_END: begin
          audio_l     <= sat(acc_l);
          audio_r     <= sat(acc_r);
          audio_valid <= 1'b1;
          acc_l       <= '0;
          acc_r       <= '0;
          restart_act <= '0;
          op_reset    <= 1'b0;
          frame_cnt   <= frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fm_frame_seq.sv
// Bench for fm_frame_seq: three instances (32ch/506, 32ch/100 for overrun, 4ch/20 for
// short frames), vector table, random frames against an arithmetic mix model.
module tb_fm_frame_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  fm_frame_seq_if bus_a ();
  fm_frame_seq_if bus_b ();
  fm_frame_seq_if bus_c ();

  logic [5:0] sel_a, sel_b;
  logic [2:0] sel_c;
  logic next_a, orst_a, kon_a, rstr_a, av_a, sum_drv_a;
  logic next_b, orst_b, kon_b, rstr_b, av_b;
  logic next_c, orst_c, kon_c, rstr_c, av_c;
  logic signed [12:0] res_drv_a;
  logic signed [15:0] al_a, ar_a, al_b, ar_b, al_c, ar_c;

  int res_tab [64];
  bit sum_tab [64];
  int vl [32], vr [32];
  bit el [32], er [32];
  assign res_drv_a = 13'(res_tab[sel_a]);
  assign sum_drv_a = sum_tab[sel_a];

  fm_frame_seq #(.NUM_CH(32), .SAMPLE_DIV(506)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .op_sel(sel_a), .op_next(next_a), .op_reset(orst_a),
    .op_kon(kon_a), .op_restart(rstr_a), .op_result(res_drv_a), .op_sum(sum_drv_a),
    .audio_l(al_a), .audio_r(ar_a), .audio_valid(av_a));
  fm_frame_seq #(.NUM_CH(32), .SAMPLE_DIV(100)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .op_sel(sel_b), .op_next(next_b), .op_reset(orst_b),
    .op_kon(kon_b), .op_restart(rstr_b), .op_result(13'sd0), .op_sum(1'b0),
    .audio_l(al_b), .audio_r(ar_b), .audio_valid(av_b));
  fm_frame_seq #(.NUM_CH(4), .SAMPLE_DIV(20)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c), .op_sel(sel_c), .op_next(next_c), .op_reset(orst_c),
    .op_kon(kon_c), .op_restart(rstr_c), .op_result(13'sd0), .op_sum(1'b0),
    .audio_l(al_c), .audio_r(ar_c), .audio_valid(av_c));

  // Per-frame record of which slots showed op_restart / op_kon on A.
  logic [63:0] rmask_cur, kmask_cur, rmask_last, kmask_last;
  always @(negedge clk)
    if (reset) begin
      rmask_cur <= '0;
      kmask_cur <= '0;
    end else if (av_a) begin
      rmask_last <= rmask_cur;
      kmask_last <= kmask_cur;
      rmask_cur  <= '0;
      kmask_cur  <= '0;
    end else if (next_a) begin
      rmask_cur[sel_a] <= rstr_a;
      kmask_cur[sel_a] <= kon_a;
    end

  int n_chk = 0, n_pass = 0, fr_model = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic bus_wr(input int d, input logic [7:0] a, input logic [31:0] w);
    case (d)
      0: begin bus_a.bus_addr = a; bus_a.bus_wrdata = w; bus_a.bus_wren = 1'b1; end
      1: begin bus_b.bus_addr = a; bus_b.bus_wrdata = w; bus_b.bus_wren = 1'b1; end
      default: begin bus_c.bus_addr = a; bus_c.bus_wrdata = w; bus_c.bus_wren = 1'b1; end
    endcase
    @(negedge clk);
    bus_a.bus_wren = 1'b0;
    bus_b.bus_wren = 1'b0;
    bus_c.bus_wren = 1'b0;
  endtask

  task automatic bus_rd(input int d, input logic [7:0] a, output logic [31:0] q);
    case (d)
      0: begin bus_a.bus_addr = a; #1 q = bus_a.bus_rddata; end
      1: begin bus_b.bus_addr = a; #1 q = bus_b.bus_rddata; end
      default: begin bus_c.bus_addr = a; #1 q = bus_c.bus_rddata; end
    endcase
  endtask

  task automatic wait_valid_a();
    int n = 0;
    @(negedge clk);
    while (!av_a && n < 2000) begin @(negedge clk); n++; end
    chk("valid_a_timeout", av_a, 1);
    fr_model++;
    #1;
  endtask

  task automatic wait_mid_a();
    int n = 0;
    @(negedge clk);
    while (!(next_a && sel_a == 6'd20) && n < 2000) begin @(negedge clk); n++; end
    chk("mid_a_timeout", next_a, 1);
    #1;
  endtask

  function automatic logic [31:0] wr_word(input int ch);
    logic [31:0] w = '0;
    w[3:0] = 4'(vl[ch]); w[7:4] = 4'(vr[ch]); w[8] = el[ch]; w[9] = er[ch];
    return w;
  endfunction

  function automatic logic [31:0] rd_word(input int ch);
    logic [31:0] w = '0;
    w[8] = el[ch]; w[9] = er[ch];
`ifdef FMSEQ_VOLUME_EN
    w[3:0] = 4'(vl[ch]); w[7:4] = 4'(vr[ch]);
`endif
    return w;
  endfunction

  task automatic apply_cfg();
    for (int ch = 0; ch < 32; ch++) bus_wr(0, 8'(8'h80 + ch), wr_word(ch));
  endtask

  task automatic set_all(input int r, input bit s, input int l, input int rr, input bit e_l, input bit e_r);
    for (int i = 0; i < 64; i++) begin res_tab[i] = r; sum_tab[i] = s; end
    for (int ch = 0; ch < 32; ch++) begin vl[ch] = l; vr[ch] = rr; el[ch] = e_l; er[ch] = e_r; end
  endtask

  // Mix model: sum over carrier slots of op_result * (vol+1) / 16 (floored), then clamp.
  function automatic int model(input bit right);
    int acc = 0;
    int v, ch;
    for (int s = 0; s < 64; s++) begin
      ch = s / 2;
      v = res_tab[s];
      if (sum_tab[s] && (right ? er[ch] : el[ch])) begin
`ifdef FMSEQ_VOLUME_EN
        v = (v * ((right ? vr[ch] : vl[ch]) + 1)) >>> 4;
`endif
        acc += v;
      end
    end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  typedef struct { int res; bit sum; bit e_l; bit e_r; int exp_l; int exp_r; } vec_t;
  vec_t tab [8];

  initial begin
    logic [31:0] q;
    int cq [$];
    int ch;
    tab[0] = '{100,   1'b1, 1'b1, 1'b0, 6400,   0};
    tab[1] = '{4095,  1'b1, 1'b1, 1'b1, 32767,  32767};
    tab[2] = '{-4096, 1'b1, 1'b1, 1'b1, -32768, -32768};
    tab[3] = '{100,   1'b0, 1'b1, 1'b1, 0,      0};
    tab[4] = '{-3,    1'b1, 1'b0, 1'b1, 0,      -192};
    tab[5] = '{511,   1'b1, 1'b1, 1'b1, 32704,  32704};
    tab[6] = '{512,   1'b1, 1'b1, 1'b0, 32767,  0};
    tab[7] = '{-512,  1'b1, 1'b0, 1'b1, 0,      -32768};
    bus_a.bus_addr = '0; bus_a.bus_wrdata = '0; bus_a.bus_wren = 1'b0;
    bus_b.bus_addr = '0; bus_b.bus_wrdata = '0; bus_b.bus_wren = 1'b0;
    bus_c.bus_addr = '0; bus_c.bus_wrdata = '0; bus_c.bus_wren = 1'b0;
    set_all(0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Phase 1: timing on C (4 ch, div 20) and overrun on B (32 ch, div 100).
    repeat (3) @(negedge clk);
    reset = 1'b0;
    goto(19); bus_rd(2, 8'h01, q); chk("c_busy_before_tick", q[0], 0);
    goto(20); bus_rd(2, 8'h01, q); chk("c_busy_at_tick", q[0], 1);
    while (cyc < 40) begin
      @(negedge clk);
      if (next_c) cq.push_back(int'(sel_c));
      if (cyc == 37) chk("c_valid_early", av_c, 0);
      if (cyc == 38) chk("c_valid_18", av_c, 1);
    end
    chk("c_sel_count", cq.size(), 8);
    for (int i = 0; i < 8; i++) chk("c_sel_order", (i < cq.size()) ? cq[i] : -1, i);
    goto(99);  bus_rd(1, 8'h01, q); chk("b_busy_99", q[0], 0);
    goto(100); bus_rd(1, 8'h01, q); chk("b_busy_100", q[0], 1);
    goto(199); bus_rd(1, 8'h00, q); chk("b_ovr_before_drop", q, 0);
    goto(201); bus_rd(1, 8'h00, q); chk("b_ovr_after_drop", q, 1);
    goto(250); bus_wr(1, 8'h00, 32'h1); bus_rd(1, 8'h00, q); chk("b_ovr_clear", q, 0);
    bus_wr(1, 8'hA0, 32'hFFFF_FFFF); bus_rd(1, 8'hA0, q); chk("b_unmapped_ch", q, 0);
    bus_rd(1, 8'h02, q); chk("b_unmapped_02", q, 0);
    goto(450); bus_wr(1, 8'h00, 32'h0); bus_rd(1, 8'h00, q); chk("b_ovr_wr0_keeps", q, 1);
    bus_wr(1, 8'h00, 32'h1); bus_rd(1, 8'h00, q); chk("b_ovr_clear2", q, 0);
    goto(590); bus_rd(1, 8'h00, q); chk("b_ovr_pre_coinc", q, 0);
    goto(599); bus_wr(1, 8'h00, 32'h1); bus_rd(1, 8'h00, q); chk("b_ovr_set_wins", q, 1);
    goto(5119); bus_rd(2, 8'h01, q); chk("c_fc_255", q[15:8], 255);
    goto(5139); bus_rd(2, 8'h01, q); chk("c_fc_wrap", q[15:8], 0);

    // Phase 2: A (32 ch, div 506).
    @(negedge clk); reset = 1'b1; fr_model = 0;
    @(negedge clk);
    chk("a_rst_audio_l", al_a, 0);
    chk("a_rst_audio_r", ar_a, 0);
    chk("a_rst_valid", av_a, 0);
    chk("a_rst_op_reset", orst_a, 1);
    chk("a_rst_wait", bus_a.bus_wait, 0);
    bus_rd(0, 8'h00, q); chk("a_rst_ctrl", q, 0);
    bus_rd(0, 8'h01, q); chk("a_rst_status", q, 0);
    @(negedge clk); reset = 1'b0;
    set_all(100, 1'b1, 15, 15, 1'b1, 1'b0);
    apply_cfg();
    goto(510); chk("a_op_reset_first", orst_a, 1);
    wait_valid_a();
    chk("a_first_l", al_a, 0);
    chk("a_first_r", ar_a, 0);
    chk("a_op_reset_cleared", orst_a, 0);

    foreach (tab[i]) begin
      set_all(tab[i].res, tab[i].sum, 15, 15, tab[i].e_l, tab[i].e_r);
      apply_cfg();
      wait_valid_a();
      chk($sformatf("tab%0d_l", i), al_a, tab[i].exp_l);
      chk($sformatf("tab%0d_r", i), ar_a, tab[i].exp_r);
    end
    bus_rd(0, 8'h01, q);
    chk("a_frame_cnt", q[15:8], fr_model & 255);
    chk("a_idle_busy", q[0], 0);

    // Volume: one carrier at -64 with vol_l 7.
    set_all(-64, 1'b0, 7, 0, 1'b1, 1'b0);
    sum_tab[1] = 1'b1;
    apply_cfg();
    wait_valid_a();
`ifdef FMSEQ_VOLUME_EN
    chk("vol_l_scaled", al_a, -32);
`else
    chk("vol_l_unscaled", al_a, -64);
`endif
    bus_rd(0, 8'h80, q); chk("vol_readback", q, rd_word(0));

    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < 64; s++) begin
        res_tab[s] = int'($urandom_range(0, 8191)) - 4096;
        sum_tab[s] = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 32; c++) begin
        vl[c] = int'($urandom_range(0, 15)); vr[c] = int'($urandom_range(0, 15));
        el[c] = 1'($urandom_range(0, 1));    er[c] = 1'($urandom_range(0, 1));
      end
      apply_cfg();
      wait_valid_a();
      chk($sformatf("rand%0d_l", f), al_a, model(1'b0));
      chk($sformatf("rand%0d_r", f), ar_a, model(1'b1));
      ch = int'($urandom_range(0, 31));
      bus_rd(0, 8'(8'h80 + ch), q); chk($sformatf("rand%0d_word", f), q, rd_word(ch));
    end

    // Key-on edge in frame N restarts ch 5 (slots 10/11) in frame N+1 only.
    set_all(0, 1'b0, 0, 0, 1'b0, 1'b0);
    apply_cfg();
    wait_mid_a();
    bus_wr(0, 8'h85, 32'h2000);
    chk("kon_no_wait", bus_a.bus_wait, 0);
    wait_valid_a(); chk("kon_frame_n_restart", rmask_last, 0);
    wait_valid_a();
    chk("kon_frame_n1_restart", rmask_last, 64'hC00);
    chk("kon_frame_n1_kon", kmask_last, 64'hC00);
    wait_mid_a();
    bus_wr(0, 8'h85, 32'h2000);
    wait_valid_a(); chk("kon_frame_n2_restart", rmask_last, 0);
    wait_valid_a(); chk("kon_rewrite_restart", rmask_last, 0);

    // Reset mid-frame clears state; the next frame outputs 0.
    wait_mid_a();
    reset = 1'b1; fr_model = 0;
    #1;
    chk("mid_rst_sel", sel_a, 0);
    chk("mid_rst_op_reset", orst_a, 1);
    chk("mid_rst_valid", av_a, 0);
    bus_rd(0, 8'h01, q); chk("mid_rst_status", q, 0);
    bus_rd(0, 8'h85, q); chk("mid_rst_ch5", q, 0);
    @(negedge clk); reset = 1'b0;
    set_all(100, 1'b1, 15, 15, 1'b1, 1'b0);
    apply_cfg();
    wait_valid_a(); chk("post_rst_first_l", al_a, 0);
    wait_valid_a(); chk("post_rst_second_l", al_a, 6400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
